// File: rtl/aes_key_expander.sv
// AES-128 key expander: produces round keys rk0..rk10, one per clock, into a
// small register file that the round engine reads by index in any order.
//
// state  | meaning
// IDLE   | no key loaded since reset; waiting for key_load
// EXPAND | writing rk[r] from rk[r-1], r = 1..10
// DONE   | all round keys stored and stable; key_load restarts
module aes_key_expander #(
    parameter int ROUNDS = 10,
    parameter bit RD_REG = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         key_load,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic         keys_valid,
    input  logic [3:0]   rd_idx,
    output logic [127:0] rd_data
);

    localparam int NKEYS = ROUNDS + 1;

    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

    // Entry x sits at bits 2047-8x; {~x,3'b111} is that top bit index.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TBL[{~x, 3'b111} -: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    state_t         state_q, state_d;
    logic [3:0]     r_q, r_d;
    logic           busy_q, busy_d;
    logic           valid_q, valid_d;
    logic [127:0]   rk_q [NKEYS];
    logic [127:0]   rk_d [NKEYS];

    logic [127:0]   prev_key, next_key, rd_sel;
    logic [31:0]    w0, w1, w2, w3, rot, sub, t, n0, n1, n2, n3;

    // Index-out-of-range selects fall through to zero (rd_idx 11..15, r=0).
    always_comb begin
        prev_key = '0;
        rd_sel   = '0;
        for (int i = 0; i < NKEYS; i++) begin
            if (r_q == 4'(i + 1)) prev_key = rk_q[i];
            if (rd_idx == 4'(i))  rd_sel   = rk_q[i];
        end
    end

    always_comb begin
        {w0, w1, w2, w3} = prev_key;
        rot      = {w3[23:0], w3[31:24]};
        sub      = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
        t        = sub ^ {rcon(r_q), 24'h0};
        n0       = w0 ^ t;
        n1       = w1 ^ n0;
        n2       = w2 ^ n1;
        n3       = w3 ^ n2;
        next_key = {n0, n1, n2, n3};
    end

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        busy_d  = busy_q;
        valid_d = valid_q;
        rk_d    = rk_q;
        case (state_q)
            IDLE, DONE: begin
                if (key_load) begin
                    rk_d[0] = key_in;
                    r_d     = 4'd1;
                    busy_d  = 1'b1;
                    valid_d = 1'b0;
                    state_d = EXPAND;
                end
            end
            EXPAND: begin
                for (int i = 1; i < NKEYS; i++) begin
                    if (r_q == 4'(i)) rk_d[i] = next_key;
                end
                r_d = r_q + 4'd1;
                if (r_q == 4'(ROUNDS)) begin
                    r_d     = '0;
                    busy_d  = 1'b0;
                    valid_d = 1'b1;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            r_q     <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            for (int i = 0; i < NKEYS; i++) rk_q[i] <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            rk_q    <= rk_d;
        end
    end

    assign busy       = busy_q;
    assign keys_valid = valid_q;

    // Registered read samples the pre-edge contents: no write bypass.
    if (RD_REG) begin : g_rd_reg
        logic [127:0] rd_data_q, rd_data_d;
        assign rd_data_d = rd_sel;
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) rd_data_q <= '0;
            else        rd_data_q <= rd_data_d;
        end
        assign rd_data = rd_data_q;
    end else begin : g_rd_comb
        assign rd_data = rd_sel;
    end

endmodule
